// File: rtl/wb_width_bridge_pkg.sv
// Shared types and width helpers for the Wishbone B3 classic width bridge.
package wb_width_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    RSP_ACK,
    RSP_ERR,
    RSP_RTY
  } rsp_e;

  typedef struct packed {
    logic [7:0] ratio;       // wider width / narrower width
    logic [7:0] lane_shift;  // log2 of the narrower side's byte count
  } width_info_t;

  function automatic width_info_t width_info(input int unsigned mw, input int unsigned sw);
    width_info_t wi;
    int unsigned narrow;
    int unsigned wide;
    narrow        = (mw < sw) ? mw : sw;
    wide          = (mw < sw) ? sw : mw;
    wi.ratio      = 8'(wide / narrow);
    wi.lane_shift = 8'($clog2(narrow / 8));
    return wi;
  endfunction

endpackage

// File: rtl/wb_width_bridge_timer.sv
// Slave ack watchdog; only instantiated when WB_WIDTH_BRIDGE_TIMEOUT_EN is defined.
module wb_width_bridge_timer #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(LIMIT - 1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expired_o = run_i && !clear_i && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_width_bridge.sv
// Wishbone B3 classic up/down width bridge with err/rty forwarding.
// Optional slave-ack watchdog enabled by defining WB_WIDTH_BRIDGE_TIMEOUT_EN.
module wb_width_bridge
  import wb_width_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int WBM_DATA_WIDTH = 16,
  parameter int WBS_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_WIDTH-1:0]       wbm_adr_i,
  input  logic [WBM_DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [WBM_DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic [WBM_DATA_WIDTH/8-1:0] wbm_sel_i,
  input  logic                        wbm_we_i,
  input  logic                        wbm_cyc_i,
  input  logic                        wbm_stb_i,
  output logic                        wbm_ack_o,
  output logic                        wbm_err_o,
  output logic                        wbm_rty_o,
  output logic [ADDR_WIDTH-1:0]       wbs_adr_o,
  output logic [WBS_DATA_WIDTH-1:0]   wbs_dat_o,
  input  logic [WBS_DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [WBS_DATA_WIDTH/8-1:0] wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i
);

  localparam int          MB         = WBM_DATA_WIDTH / 8;
  localparam int          SB         = WBS_DATA_WIDTH / 8;
  localparam bit          UPSIZE     = (MB <= SB);
  localparam width_info_t WI         = width_info(WBM_DATA_WIDTH, WBS_DATA_WIDTH);
  localparam int          R          = int'(WI.ratio);
  localparam int          NARROW_LOG = int'(WI.lane_shift);
  localparam int          MB_LOG     = UPSIZE ? NARROW_LOG : NARROW_LOG + $clog2(R);
  localparam int          SB_LOG     = UPSIZE ? NARROW_LOG + $clog2(R) : NARROW_LOG;
  localparam int          NB         = UPSIZE ? 1 : R;
  localparam int          BW         = (NB > 1) ? $clog2(NB) : 1;
  localparam int          LW         = (SB_LOG > MB_LOG) ? SB_LOG - MB_LOG : 1;

  state_e                    state_q, state_d;
  rsp_e                      rsp_q, rsp_d;
  logic [ADDR_WIDTH-1:0]     adr_q, adr_d;
  logic [WBM_DATA_WIDTH-1:0] dat_q, dat_d;
  logic [MB-1:0]             sel_q, sel_d;
  logic                      we_q, we_d;
  logic [BW-1:0]             beat_q, beat_d;
  logic                      cyc_q, cyc_d;
  logic                      stb_q, stb_d;
  logic [WBM_DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic [WBM_DATA_WIDTH-1:0] mdat_q, mdat_d;

  logic [NB-1:0]             req_act, beat_act;
  logic                      first_found, next_found;
  logic [BW-1:0]             first_idx, next_idx;
  logic [WBM_DATA_WIDTH-1:0] rd_merge;
  logic                      timeout;

  if (UPSIZE) begin : g_up
    logic [LW-1:0] lane;
    if (SB > MB) begin : g_lane
      assign lane = adr_q[SB_LOG-1:MB_LOG];
    end else begin : g_nolane
      assign lane = '0;
    end
    assign req_act   = 1'b1;
    assign beat_act  = 1'b1;
    assign wbs_adr_o = adr_q & ~ADDR_WIDTH'(SB - 1);
    assign wbs_sel_o = SB'(sel_q) << (lane * MB);
    assign wbs_dat_o = {R{dat_q}};
    assign rd_merge  = wbs_dat_i[lane*WBM_DATA_WIDTH +: WBM_DATA_WIDTH];
  end else begin : g_dn
    for (genvar k = 0; k < NB; k++) begin : g_act
      assign req_act[k]  = |wbm_sel_i[k*SB +: SB];
      assign beat_act[k] = |sel_q[k*SB +: SB];
    end
    assign wbs_adr_o = (adr_q & ~ADDR_WIDTH'(MB - 1)) | (ADDR_WIDTH'(beat_q) << SB_LOG);
    assign wbs_sel_o = sel_q[beat_q*SB +: SB];
    assign wbs_dat_o = dat_q[beat_q*WBS_DATA_WIDTH +: WBS_DATA_WIDTH];
    always_comb begin
      rd_merge = rdat_q;
      rd_merge[beat_q*WBS_DATA_WIDTH +: WBS_DATA_WIDTH] = wbs_dat_i;
    end
  end

  // Lowest active beat of the new request, and lowest active beat above the current one.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int k = NB - 1; k >= 0; k--) begin
      if (req_act[k]) begin
        first_found = 1'b1;
        first_idx   = BW'(k);
      end
      if (beat_act[k] && (k > int'(beat_q))) begin
        next_found = 1'b1;
        next_idx   = BW'(k);
      end
    end
  end

`ifdef WB_WIDTH_BRIDGE_TIMEOUT_EN
  wb_width_bridge_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_i    ((state_q == ACCESS) && cyc_q),
    .clear_i  (stb_q && wbs_ack_i),
    .expired_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    rsp_d   = rsp_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    beat_d  = beat_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    rdat_d  = rdat_q;
    mdat_d  = mdat_q;
    unique case (state_q)
      IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          adr_d   = wbm_adr_i;
          dat_d   = wbm_dat_i;
          sel_d   = wbm_sel_i;
          we_d    = wbm_we_i;
          beat_d  = first_idx;
          cyc_d   = first_found;
          stb_d   = first_found;
          rdat_d  = '0;
          rsp_d   = RSP_ACK;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!wbm_cyc_i) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          state_d = IDLE;
        end else if (!cyc_q) begin
          // Downsize request with no selected bytes: answer without touching the slave.
          rsp_d   = RSP_ACK;
          mdat_d  = rdat_q;
          state_d = RESP;
        end else if (!stb_q) begin
          stb_d = 1'b1;
        end else if (wbs_err_i || wbs_rty_i) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          rsp_d   = wbs_err_i ? RSP_ERR : RSP_RTY;
          state_d = RESP;
        end else if (wbs_ack_i) begin
          rdat_d = rd_merge;
          stb_d  = 1'b0;
          if (next_found) begin
            beat_d = next_idx;
          end else begin
            cyc_d   = 1'b0;
            rsp_d   = RSP_ACK;
            mdat_d  = rd_merge;
            state_d = RESP;
          end
        end else if (timeout) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          rsp_d   = RSP_ERR;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rsp_q   <= RSP_ACK;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      beat_q  <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      rdat_q  <= '0;
      mdat_q  <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      beat_q  <= beat_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      rdat_q  <= rdat_d;
      mdat_q  <= mdat_d;
    end
  end

  assign wbs_cyc_o = cyc_q;
  assign wbs_stb_o = stb_q;
  assign wbs_we_o  = we_q;
  assign wbm_dat_o = mdat_q;
  assign wbm_ack_o = (state_q == RESP) && (rsp_q == RSP_ACK);
  assign wbm_err_o = (state_q == RESP) && (rsp_q == RSP_ERR);
  assign wbm_rty_o = (state_q == RESP) && (rsp_q == RSP_RTY);

endmodule

// File: tb/tb_wb_width_bridge.sv
// Directed scoreboard bench for wb_width_bridge: a 16->32 upsizer and a 32->16 downsizer side by side.
module tb_wb_width_bridge;

  logic clk = 1'b0;
  logic rst_n;
  int   cycle = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Upsizer: 16-bit master, 32-bit slave
  logic [31:0] up_m_adr;  logic [15:0] up_m_wdat, up_m_rdat;  logic [1:0] up_m_sel;
  logic up_m_we, up_m_cyc, up_m_stb, up_m_ack, up_m_err, up_m_rty;
  logic [31:0] up_s_adr, up_s_wdat, up_s_rdat;  logic [3:0] up_s_sel;
  logic up_s_we, up_s_cyc, up_s_stb, up_s_ack, up_s_err, up_s_rty;

  // Downsizer: 32-bit master, 16-bit slave
  logic [31:0] dn_m_adr, dn_m_wdat, dn_m_rdat;  logic [3:0] dn_m_sel;
  logic dn_m_we, dn_m_cyc, dn_m_stb, dn_m_ack, dn_m_err, dn_m_rty;
  logic [31:0] dn_s_adr;  logic [15:0] dn_s_wdat, dn_s_rdat;  logic [1:0] dn_s_sel;
  logic dn_s_we, dn_s_cyc, dn_s_stb, dn_s_ack, dn_s_err, dn_s_rty;

  wb_width_bridge #(.ADDR_WIDTH(32), .WBM_DATA_WIDTH(16), .WBS_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) u_up (
    .clk(clk), .rst_n(rst_n),
    .wbm_adr_i(up_m_adr), .wbm_dat_i(up_m_wdat), .wbm_dat_o(up_m_rdat), .wbm_sel_i(up_m_sel),
    .wbm_we_i(up_m_we), .wbm_cyc_i(up_m_cyc), .wbm_stb_i(up_m_stb),
    .wbm_ack_o(up_m_ack), .wbm_err_o(up_m_err), .wbm_rty_o(up_m_rty),
    .wbs_adr_o(up_s_adr), .wbs_dat_o(up_s_wdat), .wbs_dat_i(up_s_rdat), .wbs_sel_o(up_s_sel),
    .wbs_we_o(up_s_we), .wbs_cyc_o(up_s_cyc), .wbs_stb_o(up_s_stb),
    .wbs_ack_i(up_s_ack), .wbs_err_i(up_s_err), .wbs_rty_i(up_s_rty)
  );

  wb_width_bridge #(.ADDR_WIDTH(32), .WBM_DATA_WIDTH(32), .WBS_DATA_WIDTH(16), .TIMEOUT_CYCLES(16)) u_dn (
    .clk(clk), .rst_n(rst_n),
    .wbm_adr_i(dn_m_adr), .wbm_dat_i(dn_m_wdat), .wbm_dat_o(dn_m_rdat), .wbm_sel_i(dn_m_sel),
    .wbm_we_i(dn_m_we), .wbm_cyc_i(dn_m_cyc), .wbm_stb_i(dn_m_stb),
    .wbm_ack_o(dn_m_ack), .wbm_err_o(dn_m_err), .wbm_rty_o(dn_m_rty),
    .wbs_adr_o(dn_s_adr), .wbs_dat_o(dn_s_wdat), .wbs_dat_i(dn_s_rdat), .wbs_sel_o(dn_s_sel),
    .wbs_we_o(dn_s_we), .wbs_cyc_o(dn_s_cyc), .wbs_stb_o(dn_s_stb),
    .wbs_ack_i(dn_s_ack), .wbs_err_i(dn_s_err), .wbs_rty_i(dn_s_rty)
  );

  // rsp: 0 ack, 1 err, 2 rty, 3 never answer
  typedef struct { logic [31:0] adr; logic [3:0] sel; logic [31:0] dat; logic we; int rsp; } beat_t;
  typedef struct { int kind; logic [31:0] dat; logic chk_dat; int lat; logic access; } resp_t;

  beat_t up_q[$];
  beat_t dn_q[$];
  resp_t m_q[$];
  int    up_rsp_cyc, dn_rsp_cyc, up_stb_cyc, dn_stb_cyc;
  bit    up_seen, dn_seen, up_cyc_seen, dn_cyc_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave model: checks each new beat against the scoreboard and answers in the same cycle.
  task automatic slave_step(input bit dn);
    logic s_cyc, s_stb, s_we, a, e, r;
    logic [31:0] s_adr, s_dat, rd;
    logic [3:0] s_sel;
    bit seen;
    beat_t b;
    if (dn) begin
      s_cyc = dn_s_cyc; s_stb = dn_s_stb; s_we = dn_s_we; s_adr = dn_s_adr;
      s_dat = 32'(dn_s_wdat); s_sel = 4'(dn_s_sel); seen = dn_seen;
      if (s_cyc) dn_cyc_seen = 1'b1;
    end else begin
      s_cyc = up_s_cyc; s_stb = up_s_stb; s_we = up_s_we; s_adr = up_s_adr;
      s_dat = up_s_wdat; s_sel = up_s_sel; seen = up_seen;
      if (s_cyc) up_cyc_seen = 1'b1;
    end
    a = 1'b0; e = 1'b0; r = 1'b0; rd = '0;
    if (s_cyc && s_stb) begin
      if (!seen) begin
        seen = 1'b1;
        if (dn && dn_stb_cyc < 0) dn_stb_cyc = cycle;
        if (!dn && up_stb_cyc < 0) up_stb_cyc = cycle;
        check("beat_expected", 64'((dn ? dn_q.size() : up_q.size()) != 0), 64'd1);
        if ((dn ? dn_q.size() : up_q.size()) != 0) begin
          if (dn) b = dn_q.pop_front(); else b = up_q.pop_front();
          check("beat_adr", s_adr, b.adr);
          check("beat_sel", s_sel, b.sel);
          check("beat_we", s_we, b.we);
          if (b.we) check("beat_wdat", s_dat, b.dat);
          else rd = b.dat;
          a = (b.rsp == 0); e = (b.rsp == 1); r = (b.rsp == 2);
          if (b.rsp != 3) begin
            if (dn) dn_rsp_cyc = cycle; else up_rsp_cyc = cycle;
          end
        end
      end
    end else begin
      seen = 1'b0;
    end
    if (dn) begin
      dn_s_ack = a; dn_s_err = e; dn_s_rty = r; dn_s_rdat = rd[15:0]; dn_seen = seen;
    end else begin
      up_s_ack = a; up_s_err = e; up_s_rty = r; up_s_rdat = rd; up_seen = seen;
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    slave_step(1'b0);
    slave_step(1'b1);
  end

  task automatic push_beat(input bit dn, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input logic we, input int rsp);
    beat_t b;
    b.adr = adr; b.sel = sel; b.dat = dat; b.we = we; b.rsp = rsp;
    if (dn) dn_q.push_back(b); else up_q.push_back(b);
  endtask

  // lat < 0: response expected one cycle after the last slave answer; else cycles after request.
  task automatic xfer(input bit dn, input logic [31:0] adr, input logic we, input logic [3:0] sel,
                      input logic [31:0] wdat, input int kind, input logic [31:0] rdat,
                      input int lat, input logic access);
    resp_t x;
    int req;
    bit got;
    logic a, e, r;
    logic [31:0] md;
    x.kind = kind; x.dat = rdat; x.chk_dat = (kind == 0) && !we; x.lat = lat; x.access = access;
    m_q.push_back(x);
    if (dn) begin
      dn_m_adr = adr; dn_m_we = we; dn_m_sel = sel; dn_m_wdat = wdat;
      dn_stb_cyc = -1; dn_cyc_seen = 1'b0; dn_m_cyc = 1'b1; dn_m_stb = 1'b1;
    end else begin
      up_m_adr = adr; up_m_we = we; up_m_sel = sel[1:0]; up_m_wdat = wdat[15:0];
      up_stb_cyc = -1; up_cyc_seen = 1'b0; up_m_cyc = 1'b1; up_m_stb = 1'b1;
    end
    req = cycle;
    got = 1'b0;
    a = 1'b0; e = 1'b0; r = 1'b0; md = '0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(posedge clk);
      #1;
      if (dn) begin a = dn_m_ack; e = dn_m_err; r = dn_m_rty; md = dn_m_rdat; end
      else    begin a = up_m_ack; e = up_m_err; r = up_m_rty; md = 32'(up_m_rdat); end
      if (a || e || r) got = 1'b1;
    end
    if (dn) begin dn_m_cyc = 1'b0; dn_m_stb = 1'b0; end
    else    begin up_m_cyc = 1'b0; up_m_stb = 1'b0; end
    x = m_q.pop_front();
    check("resp_seen", 64'(got), 64'd1);
    if (got) begin
      check("resp_onehot", 64'($countones({a, e, r})), 64'd1);
      check("resp_kind", 64'(e ? 1 : (r ? 2 : 0)), 64'(x.kind));
      if (x.chk_dat) check("resp_rdat", md, x.dat);
      if (x.lat >= 0) check("resp_lat", 64'(cycle - req), 64'(x.lat));
      else check("resp_lat", 64'(cycle), 64'((dn ? dn_rsp_cyc : up_rsp_cyc) + 1));
      if (x.access) check("stb_lat", 64'(dn ? dn_stb_cyc : up_stb_cyc), 64'(req + 1));
      else check("no_slave_cyc", 64'(dn ? dn_cyc_seen : up_cyc_seen), 64'd0);
    end
    @(posedge clk);
    #1;
    if (dn) check("resp_one_cycle", {dn_m_ack, dn_m_err, dn_m_rty}, 64'd0);
    else    check("resp_one_cycle", {up_m_ack, up_m_err, up_m_rty}, 64'd0);
    check("beats_done", 64'(dn ? dn_q.size() : up_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    up_m_adr = '0; up_m_wdat = '0; up_m_sel = '0; up_m_we = 1'b0; up_m_cyc = 1'b0; up_m_stb = 1'b0;
    dn_m_adr = '0; dn_m_wdat = '0; dn_m_sel = '0; dn_m_we = 1'b0; dn_m_cyc = 1'b0; dn_m_stb = 1'b0;
    up_s_ack = 1'b0; up_s_err = 1'b0; up_s_rty = 1'b0; up_s_rdat = '0;
    dn_s_ack = 1'b0; dn_s_err = 1'b0; dn_s_rty = 1'b0; dn_s_rdat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_up_ctl", {up_s_cyc, up_s_stb, up_s_we, up_s_sel, up_m_ack, up_m_err, up_m_rty, up_m_rdat}, 64'd0);
    check("reset_up_bus", {up_s_adr, up_s_wdat}, 64'd0);
    check("reset_dn_ctl", {dn_s_cyc, dn_s_stb, dn_s_we, dn_s_sel, dn_m_ack, dn_m_err, dn_m_rty, dn_s_wdat}, 64'd0);
    check("reset_dn_bus", {dn_s_adr, dn_m_rdat}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Upsize write, lane 1
    push_beat(0, 32'h1000, 4'b1100, 32'hBEEF_BEEF, 1'b1, 0);
    xfer(0, 32'h1002, 1'b1, 4'b0011, 32'h0000_BEEF, 0, 32'h0, -1, 1'b1);
    // Upsize reads of both lanes
    push_beat(0, 32'h1000, 4'b0011, 32'h1234_5678, 1'b0, 0);
    xfer(0, 32'h1000, 1'b0, 4'b0011, 32'h0, 0, 32'h5678, -1, 1'b1);
    push_beat(0, 32'h1000, 4'b1100, 32'h1234_5678, 1'b0, 0);
    xfer(0, 32'h1002, 1'b0, 4'b0011, 32'h0, 0, 32'h1234, -1, 1'b1);
    // Upsize retry forwarded
    push_beat(0, 32'h1004, 4'b0001, 32'h0, 1'b0, 2);
    xfer(0, 32'h1004, 1'b0, 4'b0001, 32'h0, 2, 32'h0, -1, 1'b1);

    // Downsize write, two beats
    push_beat(1, 32'h2000, 4'b0011, 32'h0000_CCDD, 1'b1, 0);
    push_beat(1, 32'h2002, 4'b0011, 32'h0000_AABB, 1'b1, 0);
    xfer(1, 32'h2000, 1'b1, 4'b1111, 32'hAABB_CCDD, 0, 32'h0, -1, 1'b1);
    // Downsize write, lower half skipped
    push_beat(1, 32'h2002, 4'b0011, 32'h0000_AABB, 1'b1, 0);
    xfer(1, 32'h2000, 1'b1, 4'b1100, 32'hAABB_CCDD, 0, 32'h0, -1, 1'b1);
    // Downsize read, partial sel in both halves
    push_beat(1, 32'h2004, 4'b0010, 32'h0000_1111, 1'b0, 0);
    push_beat(1, 32'h2006, 4'b0001, 32'h0000_2222, 1'b0, 0);
    xfer(1, 32'h2004, 1'b0, 4'b0110, 32'h0, 0, 32'h2222_1111, -1, 1'b1);
    // Downsize read, unaccessed lower half reads zero
    push_beat(1, 32'h200E, 4'b0011, 32'h0000_9999, 1'b0, 0);
    xfer(1, 32'h200C, 1'b0, 4'b1100, 32'h0, 0, 32'h9999_0000, -1, 1'b1);
    // Downsize read, error on beat 0 stops the transfer; read data holds
    push_beat(1, 32'h2010, 4'b0011, 32'h0000_5A5A, 1'b0, 1);
    xfer(1, 32'h2010, 1'b0, 4'b1111, 32'h0, 1, 32'h0, -1, 1'b1);
    check("rdat_hold_after_err", dn_m_rdat, 32'h9999_0000);
    // Downsize read, zero sel: ack at N+2 with no slave cycle
    xfer(1, 32'h2014, 1'b0, 4'b0000, 32'h0, 0, 32'h0, 2, 1'b0);

`ifdef WB_WIDTH_BRIDGE_TIMEOUT_EN
    // Stalled slave: error 16 cycles after the first stb
    push_beat(1, 32'h2018, 4'b0011, 32'h0000_5555, 1'b1, 3);
    xfer(1, 32'h2018, 1'b1, 4'b0011, 32'h0000_5555, 1, 32'h0, 17, 1'b1);
`endif

    // Reset while the slave is stalled
    push_beat(1, 32'h2020, 4'b0011, 32'h0000_7777, 1'b1, 3);
    dn_m_adr = 32'h2020; dn_m_we = 1'b1; dn_m_sel = 4'b0011; dn_m_wdat = 32'h0000_7777;
    dn_stb_cyc = -1; dn_m_cyc = 1'b1; dn_m_stb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("stall_stb_high", {dn_s_cyc, dn_s_stb}, 64'd3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_ctl", {dn_s_cyc, dn_s_stb, dn_s_we, dn_s_sel, dn_m_ack, dn_m_err, dn_m_rty, dn_s_wdat}, 64'd0);
    check("rst_mid_bus", {dn_s_adr, dn_m_rdat}, 64'd0);
    rst_n = 1'b1;
    dn_m_cyc = 1'b0; dn_m_stb = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_no_resp", {dn_m_ack, dn_m_err, dn_m_rty}, 64'd0);
    check("rst_mid_beat_issued", 64'(dn_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
